dbg_run_ctrl: RTL and testbench



---
 rtl/dbg_pkg.sv | 32 +++
 rtl/dbg_run_ctrl.sv | 139 +++++++++++++
 tb/tb_dbg_run_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared encodings for the debug run-control path.
// Imported by dbg_run_ctrl and by the JTAG-side register decoder so that
// both ends agree on command op codes, run states and halt causes.
package dbg_pkg;

  localparam int DBG_STEP_W = 16;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_HALT    = 3'd1,
    OP_RUN     = 3'd2,
    OP_STEP    = 3'd3,
    OP_SET_BP  = 3'd4,
    OP_CLR_BP  = 3'd5,
    OP_CLR_CNT = 3'd6,
    OP_RSVD    = 3'd7
  } dbg_op_e;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } dbg_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HOST = 2'd1,
    CAUSE_STEP = 2'd2,
    CAUSE_BP   = 2'd3
  } halt_cause_e;

endpackage

// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: debug run-control sequencer. Turns host commands into a
// per-cycle enable for the dbgclk gate (free-run, halt, bounded step, PC
// breakpoint) and counts enabled core cycles.
// Ports:
//   sysclk, reset      system clock, async active-high reset
//   cmd_valid/ready    host command handshake (ready low while stepping)
//   cmd_op, cmd_arg    command op code and argument (step count / bp addr)
//   pc                 core fetch PC
//   core_clk_en        enable for the dbgclk gate (combinational)
//   halted, halt_cause run status and reason for last halt
//   cycle_count        number of enabled core cycles, wraps
module dbg_run_ctrl
  import dbg_pkg::*;
#(
  parameter bit RESET_RUN = 1'b1,
  parameter int XLEN      = 32,
  parameter int STEP_W    = DBG_STEP_W
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [XLEN-1:0] cmd_arg,
  input  logic [XLEN-1:0] pc,
  output logic            core_clk_en,
  output logic            halted,
  output logic [1:0]      halt_cause,
  output logic [XLEN-1:0] cycle_count
);

  localparam dbg_state_e RST_STATE = RESET_RUN ? ST_RUNNING : ST_HALTED;

  dbg_state_e  state_q, state_d;
  halt_cause_e cause_q, cause_d;
  logic [STEP_W-1:0] step_rem_q, step_rem_d;
  logic [XLEN-1:0]   bp_addr_q, bp_addr_d;
  logic              bp_en_q, bp_en_d;
  logic              skip_q, skip_d;
  logic [XLEN-1:0]   cnt_q, cnt_d;

  logic        active, armed, bp_hit, acc;
  logic [STEP_W-1:0] step_n;
  dbg_op_e     op;

  assign op     = dbg_op_e'(cmd_op);
  assign step_n = cmd_arg[STEP_W-1:0];
  assign active = (state_q != ST_HALTED);
  // skip masks the compare for the first enabled cycle after a resume so
  // that continuing from a breakpoint fetches past it.
  assign armed  = bp_en_q & ~skip_q & (pc == bp_addr_q);
  assign bp_hit = active & armed;

  assign core_clk_en = active & ~armed;
  assign cmd_ready   = (state_q != ST_STEPPING);
  assign halted      = (state_q == ST_HALTED);
  assign halt_cause  = cause_q;
  assign cycle_count = cnt_q;
  assign acc         = cmd_valid & cmd_ready;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    step_rem_d = step_rem_q;
    bp_addr_d  = bp_addr_q;
    bp_en_d    = bp_en_q;
    skip_d     = skip_q;
    cnt_d      = cnt_q + XLEN'(core_clk_en);

    if (core_clk_en) skip_d = 1'b0;

    // Autonomous events: breakpoint beats the last step.
    if (bp_hit) begin
      state_d    = ST_HALTED;
      cause_d    = CAUSE_BP;
      step_rem_d = '0;
    end else if (state_q == ST_STEPPING) begin
      if (step_rem_q == STEP_W'(1)) begin
        state_d    = ST_HALTED;
        cause_d    = CAUSE_STEP;
        step_rem_d = '0;
      end else begin
        step_rem_d = step_rem_q - STEP_W'(1);
      end
    end

    // An accepted command overrides the state change above; a same-cycle
    // breakpoint only survives as the cause if we still end up halted.
    if (acc) begin
      unique case (op)
        OP_HALT: begin
          state_d = ST_HALTED;
          cause_d = bp_hit ? CAUSE_BP : CAUSE_HOST;
        end
        OP_RUN: begin
          state_d = ST_RUNNING;
          cause_d = cause_q;
          if (!active) skip_d = 1'b1;
        end
        OP_STEP: begin
          if (step_n != '0) begin
            state_d    = ST_STEPPING;
            cause_d    = cause_q;
            step_rem_d = step_n;
            if (!active) skip_d = 1'b1;
          end
        end
        OP_SET_BP: begin
          bp_addr_d = cmd_arg;
          bp_en_d   = 1'b1;
        end
        OP_CLR_BP:  bp_en_d = 1'b0;
        OP_CLR_CNT: cnt_d   = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= RST_STATE;
      cause_q    <= CAUSE_NONE;
      step_rem_q <= '0;
      bp_addr_q  <= '0;
      bp_en_q    <= 1'b0;
      skip_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      step_rem_q <= step_rem_d;
      bp_addr_q  <= bp_addr_d;
      bp_en_q    <= bp_en_d;
      skip_q     <= skip_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// tb_dbg_run_ctrl: directed bench for dbg_run_ctrl (RESET_RUN=1).
// A tiny core model advances pc by 4 on every enabled cycle.
module tb_dbg_run_ctrl;
  import dbg_pkg::*;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] pc;
  logic        core_clk_en;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit pc_auto = 1'b0;

  dbg_run_ctrl #(.RESET_RUN(1'b1), .XLEN(32), .STEP_W(16)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .pc          (pc),
    .core_clk_en (core_clk_en),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sysclk cycle; the core model fetches ahead if enabled this cycle.
  task automatic tick();
    logic en;
    en = core_clk_en;
    @(posedge sysclk);
    #1;
    if (pc_auto && en) pc = pc + 32'd4;
    #1;
  endtask

  task automatic send(input dbg_op_e op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = '0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = '0; pc = '0;
    tick(); tick();
    chk("rst_en",     {31'd0, core_clk_en}, 32'd1);
    chk("rst_halted", {31'd0, halted},      32'd0);
    chk("rst_ready",  {31'd0, cmd_ready},   32'd1);
    chk("rst_cnt",    cycle_count,          32'd0);
    chk("rst_cause",  {30'd0, halt_cause},  32'd0);

    // Free run for 10 cycles.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("run_cnt",   cycle_count,         32'd10);
    chk("run_en",    {31'd0, core_clk_en}, 32'd1);
    chk("run_cause", {30'd0, halt_cause},  32'd0);

    // HALT: the accepting cycle is still enabled, then frozen.
    send(OP_HALT, '0);
    chk("halt_en",     {31'd0, core_clk_en}, 32'd0);
    chk("halt_halted", {31'd0, halted},      32'd1);
    chk("halt_cause",  {30'd0, halt_cause},  32'd1);
    for (int i = 0; i < 20; i++) tick();
    chk("halt_cnt",    cycle_count,          32'd11);

    // STEP 3 from halted.
    send(OP_STEP, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("step_en",    {31'd0, core_clk_en}, 32'd1);
      chk("step_ready", {31'd0, cmd_ready},   32'd0);
      tick();
    end
    chk("step_en_off", {31'd0, core_clk_en}, 32'd0);
    chk("step_halted", {31'd0, halted},      32'd1);
    chk("step_cause",  {30'd0, halt_cause},  32'd2);
    chk("step_cnt",    cycle_count,          32'd14);

    // STEP 0 is a no-op.
    send(OP_STEP, 32'd0);
    chk("step0_en",    {31'd0, core_clk_en}, 32'd0);
    chk("step0_ready", {31'd0, cmd_ready},   32'd1);
    tick();
    chk("step0_cnt",   cycle_count,          32'd14);

    // Breakpoint at 0x10 while running from pc 0.
    pc = 32'd0; pc_auto = 1'b1;
    send(OP_SET_BP, 32'h10);
    chk("setbp_halted", {31'd0, halted}, 32'd1);
    send(OP_RUN, '0);
    for (int i = 0; i < 10 && pc != 32'h10; i++) begin
      chk("bp_pre_en", {31'd0, core_clk_en}, 32'd1);
      tick();
    end
    chk("bp_pc",        pc,                   32'h10);
    chk("bp_en_low",    {31'd0, core_clk_en}, 32'd0);
    tick();
    chk("bp_halted",    {31'd0, halted},      32'd1);
    chk("bp_cause",     {30'd0, halt_cause},  32'd3);
    chk("bp_pc_hold",   pc,                   32'h10);
    chk("bp_cnt",       cycle_count,          32'd18);

    // Resume: first cycle at the bp address is enabled.
    send(OP_RUN, '0);
    chk("resume_pc",  pc,                   32'h10);
    chk("resume_en",  {31'd0, core_clk_en}, 32'd1);
    tick();
    chk("resume_pc2", pc,                   32'h14);
    chk("resume_run", {31'd0, halted},      32'd0);
    send(OP_HALT, '0);
    chk("resume_cnt",   cycle_count,         32'd20);
    chk("resume_cause", {30'd0, halt_cause}, 32'd1);

    // STEP 5 with bp at the third stepped pc (0x18, 0x1c, 0x20).
    send(OP_SET_BP, 32'h20);
    send(OP_STEP, 32'd5);
    for (int i = 0; i < 2; i++) begin
      chk("s5_en", {31'd0, core_clk_en}, 32'd1);
      tick();
    end
    chk("s5_pc",     pc,                   32'h20);
    chk("s5_en_low", {31'd0, core_clk_en}, 32'd0);
    chk("s5_ready",  {31'd0, cmd_ready},   32'd0);
    tick();
    chk("s5_halted", {31'd0, halted},      32'd1);
    chk("s5_cause",  {30'd0, halt_cause},  32'd3);
    chk("s5_cnt",    cycle_count,          32'd22);

    // HALT while halted rewrites the cause.
    send(OP_HALT, '0);
    chk("rehalt_cause", {30'd0, halt_cause}, 32'd1);

    // CLR_CNT in an enabled cycle wins over the increment.
    send(OP_CLR_BP, '0);
    send(OP_RUN, '0);
    chk("clr_pre_en", {31'd0, core_clk_en}, 32'd1);
    send(OP_CLR_CNT, '0);
    chk("clr_cnt0",   cycle_count,          32'd0);
    tick();
    chk("clr_cnt1",   cycle_count,          32'd1);

    // Reset in the middle of STEP 100.
    send(OP_HALT, '0);
    send(OP_STEP, 32'd100);
    tick();
    chk("mid_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_en",     {31'd0, core_clk_en}, 32'd1);
    chk("mid_rst_halted", {31'd0, halted},      32'd0);
    chk("mid_rst_ready",  {31'd0, cmd_ready},   32'd1);
    chk("mid_rst_cnt",    cycle_count,          32'd0);
    chk("mid_rst_cause",  {30'd0, halt_cause},  32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_ready", {31'd0, cmd_ready},   32'd1);
    chk("post_rst_cnt",   cycle_count,          32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
